to_serial: RTL

- Parallel-to-serial converter for the multi-channel modulation datapath. It is the transmit-side counterpart of the from_serial deserializer.
- Each cycle it accepts one BW_IN-bit word per channel, all channels in lockstep. It emits each word as NO_CYC = BW_IN/BW_OUT chunks, least-significant chunk first.
- It has ready/valid handshakes on both sides, plus a one-word holding buffer so that back-to-back words stream at full rate.

---
 rtl/serdes_pkg.sv | 22 ++
 rtl/to_serial_lane.sv | 34 +++
 rtl/to_serial.sv | 128 ++++++++++++
 3 files changed

// File: rtl/serdes_pkg.sv
// Shared defaults, chunk-count helper and state view for the serializer/deserializer pair.
package serdes_pkg;

    localparam int DEF_NO_CH  = 10;
    localparam int DEF_BW_IN  = 8;
    localparam int DEF_BW_OUT = 2;

    typedef enum logic [1:0] {
        EMPTY,
        BUSY,
        FULL
    } ser_state_t;

    // Returns 0 when the wide word cannot be split into whole chunks.
    function automatic int calc_no_cyc(input int bw_in, input int bw_out);
        if (bw_out <= 0 || bw_in < bw_out || (bw_in % bw_out) != 0) begin
            return 0;
        end
        return bw_in / bw_out;
    endfunction

endpackage

// File: rtl/to_serial_lane.sv
// Per-channel datapath: shift register plus one-word holding register, steered by shared controls.
// No handshake of its own; a shift exposes the next BW_OUT-bit chunk at data_out.
module to_serial_lane #(
    parameter int BW_IN  = 8,
    parameter int BW_OUT = 2
) (
    input  logic              clk,
    input  logic [BW_IN-1:0]  data_in,
    input  logic              load_sh_from_in,
    input  logic              load_sh_from_hold,
    input  logic              load_hold,
    input  logic              shift,
    output logic [BW_OUT-1:0] data_out
);

    logic [BW_IN-1:0] sh;
    logic [BW_IN-1:0] hold;

    always_ff @(posedge clk) begin
        if (load_sh_from_in) begin
            sh <= data_in;
        end else if (load_sh_from_hold) begin
            sh <= hold;
        end else if (shift) begin
            sh <= sh >> BW_OUT;
        end
        if (load_hold) begin
            hold <= data_in;
        end
    end

    assign data_out = sh[BW_OUT-1:0];

endmodule

// File: rtl/to_serial.sv
// Parallel-to-serial converter: NO_CH lockstep words leave as NO_CYC chunks, least-significant first.
// First chunk one cycle after accept; outputs hold under !rdy_out, and a hold buffer keeps words gap-free.
module to_serial
    import serdes_pkg::*;
#(
    parameter int NO_CH  = DEF_NO_CH,
    parameter int BW_IN  = DEF_BW_IN,
    parameter int BW_OUT = DEF_BW_OUT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          vld_in,
    output logic                          rdy_in,
    input  logic [NO_CH-1:0][BW_IN-1:0]   data_in,
    output logic                          vld_out,
    input  logic                          rdy_out,
    output logic [NO_CH-1:0][BW_OUT-1:0]  data_out,
    output logic                          last_out
);

    localparam int NO_CYC  = calc_no_cyc(BW_IN, BW_OUT);
    localparam int CNTR_BW = (NO_CYC > 1) ? $clog2(NO_CYC) : 1;
    localparam logic [CNTR_BW-1:0] LAST_CNT = CNTR_BW'(NO_CYC - 1);

    if (NO_CYC == 0) begin : g_bad_ratio
        $error("to_serial: BW_IN (%0d) must be an integer multiple of BW_OUT (%0d)", BW_IN, BW_OUT);
    end

    ser_state_t         state;
    ser_state_t         nxt_state;
    logic [CNTR_BW-1:0] cnt;
    logic [CNTR_BW-1:0] nxt_cnt;
    logic               accept;
    logic               xfer;
    logic               at_last;
    logic               load_sh_from_in;
    logic               load_sh_from_hold;
    logic               load_hold;
    logic               shift;

    assign rdy_in  = (state != FULL) && !rst;
    assign accept  = vld_in && rdy_in;
    assign xfer    = vld_out && rdy_out;
    assign at_last = (cnt == LAST_CNT);

    always_comb begin
        nxt_state         = state;
        nxt_cnt           = cnt;
        load_sh_from_in   = 1'b0;
        load_sh_from_hold = 1'b0;
        load_hold         = 1'b0;
        shift             = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_sh_from_in = 1'b1;
                    nxt_cnt         = '0;
                    nxt_state       = BUSY;
                end
            end
            BUSY: begin
                if (xfer && at_last) begin
                    // A word arriving with the last chunk replaces it directly: no bubble.
                    nxt_cnt = '0;
                    if (accept) begin
                        load_sh_from_in = 1'b1;
                    end else begin
                        nxt_state = EMPTY;
                    end
                end else begin
                    if (xfer) begin
                        shift   = 1'b1;
                        nxt_cnt = cnt + CNTR_BW'(1);
                    end
                    if (accept) begin
                        load_hold = 1'b1;
                        nxt_state = FULL;
                    end
                end
            end
            FULL: begin
                if (xfer && at_last) begin
                    load_sh_from_hold = 1'b1;
                    nxt_cnt           = '0;
                    nxt_state         = BUSY;
                end else if (xfer) begin
                    shift   = 1'b1;
                    nxt_cnt = cnt + CNTR_BW'(1);
                end
            end
            default: begin
                nxt_state = EMPTY;
                nxt_cnt   = '0;
            end
        endcase
    end

    // vld_out/last_out are registered from the next-state view so they leave the block glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            cnt      <= '0;
            vld_out  <= 1'b0;
            last_out <= 1'b0;
        end else begin
            state    <= nxt_state;
            cnt      <= nxt_cnt;
            vld_out  <= (nxt_state != EMPTY);
            last_out <= (nxt_state != EMPTY) && (nxt_cnt == LAST_CNT);
        end
    end

    for (genvar i = 0; i < NO_CH; i++) begin : g_lane
        to_serial_lane #(
            .BW_IN (BW_IN),
            .BW_OUT(BW_OUT)
        ) u_lane (
            .clk              (clk),
            .data_in          (data_in[i]),
            .load_sh_from_in  (load_sh_from_in),
            .load_sh_from_hold(load_sh_from_hold),
            .load_hold        (load_hold),
            .shift            (shift),
            .data_out         (data_out[i])
        );
    end

endmodule
